// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg -- shared constants and types for alu_ctrl_seq and md_iter.
//   ALUCtrl operation codes, funct7/funct3 field values, ALUOp encodings
//   and the multiply/divide sequencer state type.
package alu_ctrl_pkg;

  // ALUCtrl operation codes
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_XOR  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_MD   = 4'd5;  // select md_result
  localparam logic [3:0] ALU_LDI0 = 4'd6;
  localparam logic [3:0] ALU_LDI5 = 4'd7;
  localparam logic [3:0] ALU_BR   = 4'd8;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  // funct3 values, integer R-type
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 values, multiply/divide (funct7 = F7_MD)
  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIVU  = 3'b101;
  localparam logic [2:0] F3_REMU  = 3'b111;

  // ALUOp encodings
  localparam logic [1:0] OP_LDIMM  = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } md_state_t;

endpackage

// File: rtl/alu_ctrl_seq_md_iter.sv
// md_iter -- iterative unsigned multiply/divide datapath, one step per cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture a, b, funct3 and clear the accumulator
//   step       : perform one shift-add (multiply) or restoring-subtract
//                (divide) step
//   funct3     : mul/div selector captured on load
//   a, b       : operands (multiplicand/multiplier, dividend/divisor)
//   result     : value the final step produces for the captured funct3;
//                only meaningful during the last step
module md_iter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  // hi/lo share roles: multiply keeps the {hi,lo} product with the
  // multiplier shifting out of lo; divide keeps remainder in hi and the
  // dividend/quotient shifting through lo.
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [XLEN-1:0] hi_d, lo_d, addend;
  logic [2:0]      f3_q;
  logic [XLEN:0]   sum, shifted, diff;

  always_comb begin
    addend  = lo_q[0] ? b_q : '0;
    sum     = {1'b0, hi_q} + {1'b0, addend};
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (f3_q[2]) begin
      // Divide: diff[XLEN] is the borrow. With b=0 the remainder never
      // reaches bit XLEN-1 before the last step, so quotient ends all ones
      // and remainder ends equal to the dividend.
      hi_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    result = '0;
    case (f3_q)
      F3_MUL:   result = lo_d;
      F3_MULHU: result = hi_d;
      F3_DIVU:  result = lo_d;
      F3_REMU:  result = hi_d;
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
      f3_q <= '0;
    end else if (load) begin
      hi_q <= '0;
      lo_q <= a;
      b_q  <= b;
      f3_q <= funct3;
    end else if (step) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq -- ALU control decode plus multi-cycle mul/div sequencer.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   valid_i      : decode-slot instruction valid
//   flush_i      : synchronous abort of a multi-cycle op
//   funct_i      : {funct7, funct3}
//   ALUOp_i      : 00 load/imm, 01 branch, 10 R-type, 11 reserved
//   rs1_i, rs2_i : mul/div operands
//   ALUCtrl_o    : combinational ALU operation code
//   ready_o      : sequencer idle, can accept a mul/div op
//   md_busy_o    : stall request while an op is in flight
//   md_valid_o   : one-cycle pulse, md_result_o final
//   md_result_o  : mul/div result, held until the next completion
// Build option: ALU_CTRL_SEQ_EARLY_OUT_EN -- zero-operand multiply and
//   divide-by-zero complete straight from accept without iterating.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [9:0]        funct_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              ready_o,
  output logic              md_busy_o,
  output logic              md_valid_o,
  output logic [XLEN-1:0]   md_result_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic [3:0]       code;
  logic             is_md;
  logic             accept;
  logic             step;
  logic             early_hit;
  logic [XLEN-1:0]  early_result;
  logic [XLEN-1:0]  iter_result;
  logic [CNT_W-1:0] cnt_q;
  md_state_t        state_q, state_d;

  assign funct7 = funct_i[9:3];
  assign funct3 = funct_i[2:0];
  assign is_md  = (ALUOp_i == OP_RTYPE) && (funct7 == F7_MD);

  // ALU control decode
  always_comb begin
    code = ALU_ADD;
    case (ALUOp_i)
      OP_RTYPE: begin
        if (funct7 == F7_MD) begin
          code = ALU_MD;
        end else if (funct7 == F7_BASE) begin
          case (funct3)
            F3_AND:  code = ALU_AND;
            F3_XOR:  code = ALU_XOR;
            F3_SLL:  code = ALU_SLL;
            F3_ADD:  code = ALU_ADD;
            default: code = ALU_ADD;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          code = ALU_SUB;
        end
      end
      OP_LDIMM: begin
        if (funct3 == F3_ADD)     code = ALU_LDI0;
        else if (funct3 == F3_SR) code = ALU_LDI5;
      end
      OP_BRANCH: code = ALU_BR;
      default:   code = ALU_ADD;
    endcase
  end

  assign ALUCtrl_o = CTRL_W'(code);

`ifdef ALU_CTRL_SEQ_EARLY_OUT_EN
  always_comb begin
    early_hit    = 1'b0;
    early_result = '0;
    case (funct3)
      F3_MUL, F3_MULHU: begin
        if (rs1_i == '0 || rs2_i == '0) early_hit = 1'b1;
      end
      F3_DIVU: begin
        if (rs2_i == '0) begin
          early_hit    = 1'b1;
          early_result = '1;
        end
      end
      F3_REMU: begin
        if (rs2_i == '0) begin
          early_hit    = 1'b1;
          early_result = rs1_i;
        end
      end
      default: early_hit = 1'b0;
    endcase
  end
`else
  assign early_hit    = 1'b0;
  assign early_result = '0;
`endif

  // Sequencer next-state and outputs
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && is_md && !flush_i) begin
          accept  = 1'b1;
          state_d = early_hit ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        step = !flush_i;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  assign ready_o    = (state_q == ST_IDLE);
  assign md_busy_o  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign md_valid_o = (state_q == ST_DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      md_result_o <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_W'(XLEN - 1);
      end else if (step && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Result only moves on a completing step or an early-out accept,
      // so a flushed op leaves the previous value visible.
      if (accept && early_hit) begin
        md_result_o <= early_result;
      end else if (step && cnt_q == '0) begin
        md_result_o <= iter_result;
      end
    end
  end

  md_iter #(
    .XLEN(XLEN)
  ) u_md_iter (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (accept),
    .step   (step),
    .funct3 (funct3),
    .a      (rs1_i),
    .b      (rs2_i),
    .result (iter_result)
  );

endmodule
